// File: rtl/vector_csel_adder_pipe.sv
// vector_csel_adder_pipe: two-stage pipelined carry-select adder with a
// per-transaction lane split (1 x W, 2 x W/2 or 4 x W/4), a carry-in and a
// carry-out per lane, and valid/ready handshakes on both sides.
// Stage 1 precomputes each block's sum for carry 0 and carry 1. Stage 2
// resolves the block carry chain, cutting it at lane boundaries.
// Optional feature macro: VECTOR_CSEL_ADDER_OVF_EN adds a per-lane signed
// overflow output that is registered alongside sum.
module vector_csel_adder_pipe #(
  parameter int ADDER_WIDTH = 32,
  parameter int BLOCK_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             mode,
  input  logic [ADDER_WIDTH-1:0] operand_a,
  input  logic [ADDER_WIDTH-1:0] operand_b,
  input  logic [3:0]             carry_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDER_WIDTH-1:0] sum,
  output logic [3:0]             carry_out
`ifdef VECTOR_CSEL_ADDER_OVF_EN
  ,
  output logic [3:0]             overflow
`endif
);

  localparam int NB = ADDER_WIDTH / BLOCK_WIDTH;  // blocks in the full word
  localparam int HB = NB / 2;                     // blocks per half lane
  localparam int QB = NB / 4;                     // blocks per quarter lane

  // Stage 1 registers
  logic                                s1_valid;
  logic [1:0]                          s1_mode;
  logic [3:0]                          s1_cin;
  logic [NB-1:0][BLOCK_WIDTH-1:0]      s1_sum0;
  logic [NB-1:0][BLOCK_WIDTH-1:0]      s1_sum1;
  logic [NB-1:0]                       s1_c0;
  logic [NB-1:0]                       s1_c1;

  // Stage 1 inputs precomputed per block
  logic [NB-1:0][BLOCK_WIDTH-1:0]      pre_sum0;
  logic [NB-1:0][BLOCK_WIDTH-1:0]      pre_sum1;
  logic [NB-1:0]                       pre_c0;
  logic [NB-1:0]                       pre_c1;

  // Stage 2 resolved values
  logic [ADDER_WIDTH-1:0]              res_sum;
  logic [3:0]                          res_cout;

  logic s2_load;
  logic s1_load;

`ifdef VECTOR_CSEL_ADDER_OVF_EN
  // MSB propagate bit per block; with the selected sum bit it recovers the
  // carry into the MSB without keeping the operands around.
  logic [NB-1:0] pre_pmsb;
  logic [NB-1:0] s1_pmsb;
  logic [3:0]    res_ovf;
`endif

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // Per-block sums for both possible incoming carries
  always_comb begin
    pre_sum0 = '0;
    pre_sum1 = '0;
    pre_c0   = '0;
    pre_c1   = '0;
`ifdef VECTOR_CSEL_ADDER_OVF_EN
    pre_pmsb = '0;
`endif
    for (int j = 0; j < NB; j++) begin
      {pre_c0[j], pre_sum0[j]} = {1'b0, operand_a[j*BLOCK_WIDTH +: BLOCK_WIDTH]}
                               + {1'b0, operand_b[j*BLOCK_WIDTH +: BLOCK_WIDTH]};
      {pre_c1[j], pre_sum1[j]} = {1'b0, operand_a[j*BLOCK_WIDTH +: BLOCK_WIDTH]}
                               + {1'b0, operand_b[j*BLOCK_WIDTH +: BLOCK_WIDTH]}
                               + (BLOCK_WIDTH+1)'(1);
`ifdef VECTOR_CSEL_ADDER_OVF_EN
      pre_pmsb[j] = operand_a[j*BLOCK_WIDTH + BLOCK_WIDTH - 1]
                  ^ operand_b[j*BLOCK_WIDTH + BLOCK_WIDTH - 1];
`endif
    end
  end

  // Stage 1 register: capture precomputed blocks with their mode and carries
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_cin   <= '0;
      s1_sum0  <= '0;
      s1_sum1  <= '0;
      s1_c0    <= '0;
      s1_c1    <= '0;
`ifdef VECTOR_CSEL_ADDER_OVF_EN
      s1_pmsb  <= '0;
`endif
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= mode;
        s1_cin  <= carry_in;
        s1_sum0 <= pre_sum0;
        s1_sum1 <= pre_sum1;
        s1_c0   <= pre_c0;
        s1_c1   <= pre_c1;
`ifdef VECTOR_CSEL_ADDER_OVF_EN
        s1_pmsb <= pre_pmsb;
`endif
      end
    end
  end

  // Serial block carry chain, restarted from the lane carry-in at each lane start
  always_comb begin
    int         lb;
    logic [1:0] lane;
    logic       c;
    logic       cn;
    lb       = NB;
    lane     = 2'd0;
    c        = 1'b0;
    cn       = 1'b0;
    res_sum  = '0;
    res_cout = '0;
`ifdef VECTOR_CSEL_ADDER_OVF_EN
    res_ovf  = '0;
`endif
    for (int j = 0; j < NB; j++) begin
      case (s1_mode)
        2'b01:   begin lb = HB; lane = 2'(j / HB); end
        2'b10:   begin lb = QB; lane = 2'(j / QB); end
        default: begin lb = NB; lane = 2'd0;       end
      endcase
      if (j % lb == 0) c = s1_cin[lane];
      res_sum[j*BLOCK_WIDTH +: BLOCK_WIDTH] = c ? s1_sum1[j] : s1_sum0[j];
      cn = c ? s1_c1[j] : s1_c0[j];
      if (j % lb == lb - 1) begin
        res_cout[lane] = cn;
`ifdef VECTOR_CSEL_ADDER_OVF_EN
        res_ovf[lane] = s1_pmsb[j] ^ res_sum[j*BLOCK_WIDTH + BLOCK_WIDTH - 1] ^ cn;
`endif
      end
      c = cn;
    end
  end

  // Stage 2 register: output holds while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= '0;
`ifdef VECTOR_CSEL_ADDER_OVF_EN
      overflow  <= '0;
`endif
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum       <= res_sum;
        carry_out <= res_cout;
`ifdef VECTOR_CSEL_ADDER_OVF_EN
        overflow  <= res_ovf;
`endif
      end
    end
  end

endmodule

// File: tb/tb_vector_csel_adder_pipe.sv
// Testbench for vector_csel_adder_pipe: lane-wise arithmetic model plus an
// in-flight queue that predicts out_valid, in_ready and each result.
module tb_vector_csel_adder_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   mode;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [3:0]   carry_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic [3:0]   carry_out;
`ifdef VECTOR_CSEL_ADDER_OVF_EN
  logic [3:0]   overflow;
`endif

  vector_csel_adder_pipe #(.ADDER_WIDTH(W), .BLOCK_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .operand_a(operand_a), .operand_b(operand_b),
    .carry_in(carry_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out)
`ifdef VECTOR_CSEL_ADDER_OVF_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] s;
    logic [3:0]   co;
    logic [3:0]   ov;
    int           acc;
  } exp_t;
  exp_t q[$];

  function automatic void chk(string nm, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endfunction

  // Lane-wise unsigned add with per-lane carry and signed overflow
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [1:0] m, input logic [3:0] ci,
                                output logic [W-1:0] s, output logic [3:0] co,
                                output logic [3:0] ov);
    int lanes, lw;
    longint unsigned mask, x, y, t;
    logic sa, sb, ss;
    lanes = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
    lw    = W / lanes;
    mask  = (64'd1 << lw) - 64'd1;
    s = '0; co = '0; ov = '0;
    for (int i = 0; i < lanes; i++) begin
      x = (64'(a) >> (i*lw)) & mask;
      y = (64'(b) >> (i*lw)) & mask;
      t = x + y + 64'(ci[i]);
      s = s | W'((t & mask) << (i*lw));
      co[i] = t[lw];
      sa = x[lw-1]; sb = y[lw-1]; ss = t[lw-1];
      ov[i] = (sa == sb) && (ss != sa);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Compare process: check outputs against the queue, then apply the
  // transfers that will happen on the coming edge.
  bit seen_rst = 0;
  bit after_rst = 0;
  always @(negedge clk) begin
    bit exp_valid, exp_ready;
    exp_t e;
    exp_valid = (q.size() > 0) && (q[0].acc <= cyc - 1);
    exp_ready = !((q.size() >= 2) && exp_valid && !out_ready);
    if (seen_rst) begin
      if (after_rst) begin
        chk("reset_sum", sum, '0);
        chk("reset_carry_out", W'(carry_out), '0);
`ifdef VECTOR_CSEL_ADDER_OVF_EN
        chk("reset_overflow", W'(overflow), '0);
`endif
      end
      chk("out_valid", W'(out_valid), W'(exp_valid));
      chk("in_ready", W'(in_ready), W'(exp_ready));
      if (exp_valid && out_valid) begin
        chk("sum", sum, q[0].s);
        chk("carry_out", W'(carry_out), W'(q[0].co));
`ifdef VECTOR_CSEL_ADDER_OVF_EN
        chk("overflow", W'(overflow), W'(q[0].ov));
`endif
      end
    end
    if (rst) begin
      q.delete();
      seen_rst = 1;
    end else begin
      if (exp_valid && out_ready) void'(q.pop_front());
      if (in_valid && exp_ready) begin
        model(operand_a, operand_b, mode, carry_in, e.s, e.co, e.ov);
        e.acc = cyc + 1;
        q.push_back(e);
      end
    end
    after_rst = rst;
  end

  task automatic drive(input logic [1:0] m, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [3:0] ci);
    mode = m; operand_a = a; operand_b = b; carry_in = ci;
  endtask

  task automatic send(input logic [1:0] m, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [3:0] ci);
    bit ok;
    ok = 0;
    drive(m, a, b, ci);
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
    end
  endtask

  initial begin
    logic [W-1:0] s;
    logic [3:0]   co, ov;

    // Hand-computed expectations pin the model itself
    model(32'hFFFF_FFFF, 32'h0, 2'b00, 4'b0001, s, co, ov);
    chk("pin1_sum", s, 32'h0000_0000);  chk("pin1_co", W'(co), 32'h1);
    model(32'h80FF_7F01, 32'h8001_0101, 2'b10, 4'b0000, s, co, ov);
    chk("pin2_sum", s, 32'h0000_8002);  chk("pin2_co", W'(co), 32'hC);
    chk("pin2_ov", W'(ov), 32'hA);
    model(32'h0001_FFFF, 32'h0000_0001, 2'b01, 4'b0000, s, co, ov);
    chk("pin3_sum", s, 32'h0001_0000);  chk("pin3_co", W'(co), 32'h1);
    model(32'h0001_FFFF, 32'h0000_0001, 2'b11, 4'b0000, s, co, ov);
    chk("pin4_sum", s, 32'h0002_0000);  chk("pin4_co", W'(co), 32'h0);
    model(32'h0000_007F, 32'h0000_0001, 2'b10, 4'b0000, s, co, ov);
    chk("pin5_sum", s, 32'h0000_0080);  chk("pin5_ov", W'(ov), 32'h1);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(2'b00, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors
    out_ready = 1'b1;
    send(2'b00, 32'hFFFF_FFFF, 32'h0, 4'b0001);
    send(2'b10, 32'h80FF_7F01, 32'h8001_0101, 4'b0000);
    send(2'b01, 32'h0001_FFFF, 32'h0000_0001, 4'b0000);
    send(2'b11, 32'h0001_FFFF, 32'h0000_0001, 4'b0000);
    send(2'b10, 32'h0000_007F, 32'h0000_0001, 4'b0000);
    send(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1111);
    send(2'b01, 32'hFFFF_FFFF, 32'h0, 4'b0011);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: two accepts, then in_ready drops until drain starts
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(2'b00, 32'h1111_1111, 32'h2222_2222, 4'b0);
    @(posedge clk); #1;
    drive(2'b01, 32'h0000_FFFF, 32'h0000_0001, 4'b0001);
    @(posedge clk); #1;
    drive(2'b10, 32'h0102_0304, 32'h0506_0708, 4'b1010);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready_low", W'(in_ready), 32'h0);
      chk("bp_head_sum", sum, 32'h3333_3333);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_high", W'(in_ready), 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset with both stages full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(2'b00, 32'hDEAD_BEEF, 32'h1, 4'b0);
    @(posedge clk); #1;
    drive(2'b00, 32'hCAFE_0000, 32'h1, 4'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", W'(out_valid), 32'h0);
    chk("rst_in_ready", W'(in_ready), 32'h1);
    chk("rst_sum", sum, 32'h0);
    @(posedge clk); #1;

    // Randomised traffic with random backpressure
    for (int k = 0; k < 3000; k++) begin
      logic [W-1:0] a, b;
      int pa, pb;
      pa = $urandom_range(0, 7);
      pb = $urandom_range(0, 7);
      a = (pa == 0) ? '1 : (pa == 1) ? '0 : W'($urandom);
      b = (pb == 0) ? '1 : (pb == 1) ? '0 : W'($urandom);
      drive(2'($urandom_range(0, 3)), a, b, 4'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = (k % 500 < 250) ? ($urandom_range(0, 3) != 0)
                                  : ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end

    // Drain with a bounded wait
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      @(posedge clk); #1;
    end
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d results pending expected 0", q.size());
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
